// File: rtl/neuron_pkg.sv
// Shared types and FP32 constants for the LIF neuron datapath.
// Holds the accumulator FSM state encoding and IEEE-754 single-precision field layout.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_LSB  = 0;

    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_30_0     = 32'h41f0_0000;
    localparam logic [31:0] FP32_27_84    = 32'h41de_b852;

    // Both signed zeros have an all-zero magnitude field.
    function automatic logic fp32_is_zero(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_MAN_LSB] == 31'd0);
    endfunction

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational FP32 adder/subtractor, round-to-nearest-even, subnormals flushed to zero.
// exception_o flags an Inf/NaN operand or an overflowing result.
module Addition_Subtraction
    import neuron_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        op_i,
    output logic        exception_o,
    output logic [31:0] result_o
);

    logic               sign_a, sign_b, sign_big, sign_small;
    logic [7:0]         exp_a, exp_b, exp_big, exp_small, exp_diff;
    logic [23:0]        man_a, man_b;
    logic [26:0]        mant_big, mant_small, mant_shift, shift_mask, norm;
    logic [27:0]        sum;
    logic [4:0]         hi, lz;
    logic signed [10:0] exp_norm, exp_final;
    logic               round_up;
    logic [24:0]        rounded;
    logic [22:0]        man_out;

    // NOTE: every signal gets a value before any branch, so no path leaves one unassigned and infers a latch.
    always_comb begin
        sign_a = a_i[FP_SIGN_BIT];
        sign_b = b_i[FP_SIGN_BIT] ^ op_i;
        exp_a  = a_i[FP_EXP_MSB:FP_EXP_LSB];
        exp_b  = b_i[FP_EXP_MSB:FP_EXP_LSB];
        man_a  = (exp_a == 8'd0) ? 24'd0 : {1'b1, a_i[FP_MAN_MSB:FP_MAN_LSB]};
        man_b  = (exp_b == 8'd0) ? 24'd0 : {1'b1, b_i[FP_MAN_MSB:FP_MAN_LSB]};

        // Order operands by magnitude so the subtraction below never goes negative.
        if ({exp_b, man_b} > {exp_a, man_a}) begin
            sign_big   = sign_b;
            sign_small = sign_a;
            exp_big    = exp_b;
            exp_small  = exp_a;
            mant_big   = {man_b, 3'b000};
            mant_small = {man_a, 3'b000};
        end else begin
            sign_big   = sign_a;
            sign_small = sign_b;
            exp_big    = exp_a;
            exp_small  = exp_b;
            mant_big   = {man_a, 3'b000};
            mant_small = {man_b, 3'b000};
        end

        exp_diff   = exp_big - exp_small;
        shift_mask = (exp_diff >= 8'd27) ? {27{1'b1}} : ((27'd1 << exp_diff) - 27'd1);
        mant_shift = (exp_diff >= 8'd27) ? 27'd0 : (mant_small >> exp_diff);
        mant_shift[0] = mant_shift[0] | (|(mant_small & shift_mask));

        if (sign_big == sign_small) begin
            sum = {1'b0, mant_big} + {1'b0, mant_shift};
        end else begin
            sum = {1'b0, mant_big} - {1'b0, mant_shift};
        end

        hi = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) hi = 5'(i);
        end
        lz = 5'd26 - hi;

        if (sum[27]) begin
            norm     = {sum[27:2], sum[1] | sum[0]};
            exp_norm = $signed({3'b000, exp_big}) + 11'sd1;
        end else begin
            norm     = sum[26:0] << lz;
            exp_norm = $signed({3'b000, exp_big}) - $signed({6'd0, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rounded[24]) begin
            exp_final = exp_norm + 11'sd1;
            man_out   = rounded[23:1];
        end else begin
            exp_final = exp_norm;
            man_out   = rounded[22:0];
        end

        exception_o = (exp_a == 8'hff) || (exp_b == 8'hff);
        if (sum == 28'd0) begin
            result_o = FP32_POS_ZERO;
        end else if (exp_final <= 11'sd0) begin
            result_o = {sign_big, 31'd0};
        end else if (exp_final >= 11'sd255) begin
            result_o    = {sign_big, 8'hff, 23'd0};
            exception_o = 1'b1;
        end else begin
            result_o = {sign_big, exp_final[7:0], man_out};
        end
    end

endmodule

// File: rtl/fp32_ge.sv
// Combinational FP32 a >= b comparator (NaN inputs unsupported).
// Sign-magnitude ordering, with +0 and -0 treated as equal.
module fp32_ge
    import neuron_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        ge_o
);

    always_comb begin
        if (fp32_is_zero(a_i) && fp32_is_zero(b_i)) begin
            ge_o = 1'b1;
        end else begin
            case ({a_i[FP_SIGN_BIT], b_i[FP_SIGN_BIT]})
                2'b01:   ge_o = 1'b1;
                2'b10:   ge_o = 1'b0;
                2'b00:   ge_o = (a_i[FP_EXP_MSB:FP_MAN_LSB] >= b_i[FP_EXP_MSB:FP_MAN_LSB]);
                // Both negative: the larger magnitude is the smaller value.
                default: ge_o = (a_i[FP_EXP_MSB:FP_MAN_LSB] <= b_i[FP_EXP_MSB:FP_MAN_LSB]);
            endcase
        end
    end

endmodule

// File: rtl/lif_potential_accumulator.sv
// Per-neuron membrane accumulator: loads the decayed potential, sums FP32 weights,
// fires/resets against threshold at timestep end, then hands the potential back.
module lif_potential_accumulator
    import neuron_pkg::*;
#(
    parameter logic [31:0] INIT_POTENTIAL = FP32_27_84,
    parameter logic [31:0] THRESHOLD      = FP32_30_0,
    parameter logic [31:0] V_RESET        = FP32_POS_ZERO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decay_valid,
    input  logic [31:0] decayed_potential,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic [31:0] weight,
    input  logic        ts_end,
    output logic [31:0] new_potential,
    output logic        new_potential_valid,
    input  logic        new_potential_ready,
    output logic        spike,
    output logic        err
);

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic        spike_q, spike_d;
    logic        err_q, err_d;
    logic [31:0] add_sum;
    logic        add_exc;
    logic        acc_ge_thr;

    Addition_Subtraction u_adder (
        .a_i         (acc_q),
        .b_i         (weight),
        .op_i        (1'b0),
        .exception_o (add_exc),
        .result_o    (add_sum)
    );

    fp32_ge u_ge (
        .a_i  (acc_q),
        .b_i  (THRESHOLD),
        .ge_o (acc_ge_thr)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        spike_d = 1'b0;
        err_d   = err_q;

        if (decay_valid && (state_q != IDLE)) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (decay_valid) begin
                    acc_d   = decayed_potential;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // A weight arriving alongside ts_end is still summed before firing.
                if (weight_valid) begin
                    if (add_exc) err_d = 1'b1;
                    else         acc_d = add_sum;
                end
                if (ts_end) state_d = FIRE;
            end
            FIRE: begin
                if (acc_ge_thr) begin
                    spike_d = 1'b1;
                    acc_d   = V_RESET;
                end
                state_d = OUT;
            end
            OUT: begin
                if (new_potential_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= INIT_POTENTIAL;
            spike_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
            err_q   <= err_d;
        end
    end

    assign weight_ready        = (state_q == ACCUM);
    assign new_potential_valid = (state_q == OUT);
    assign new_potential       = acc_q;
    assign spike               = spike_q;
    assign err                 = err_q;

endmodule
